// File: rtl/conv_window_gen_if.sv
// Column-in / window-out bundle for conv_window_gen.
// WINGEN_POS_EN adds the win_x / win_y position signals.
interface conv_window_gen_if #(
    parameter int WORDWIDTH  = 32,
    parameter int WEIGHTLEN  = 5,
    parameter int FIG_WIDTH  = 28,
    parameter int FIG_HEIGHT = 28
);
    localparam int COL_ROWS = FIG_HEIGHT - WEIGHTLEN + 1;
    localparam int XW = (FIG_WIDTH > 1) ? $clog2(FIG_WIDTH) : 1;
    localparam int YW = (COL_ROWS > 1) ? $clog2(COL_ROWS) : 1;

    logic [WORDWIDTH*WEIGHTLEN-1:0]           col_in;
    logic                                     col_valid;
    logic                                     col_ready;
    logic [WORDWIDTH*WEIGHTLEN*WEIGHTLEN-1:0] win_out;
    logic                                     win_valid;
    logic                                     win_ready;
    logic                                     frame_done;
    logic                                     overflow;
    logic                                     clr_overflow;
`ifdef WINGEN_POS_EN
    logic [XW-1:0]                            win_x;
    logic [YW-1:0]                            win_y;
`endif

    modport master (
        output col_in, col_valid, win_ready, clr_overflow,
        input  col_ready, win_out, win_valid, frame_done, overflow
`ifdef WINGEN_POS_EN
        , input win_x, win_y
`endif
    );

    modport slave (
        input  col_in, col_valid, win_ready, clr_overflow,
        output col_ready, win_out, win_valid, frame_done, overflow
`ifdef WINGEN_POS_EN
        , output win_x, win_y
`endif
    );
endinterface

// File: rtl/conv_window_gen.sv
// Shifts pixel columns into a KxK window and emits strided convolution windows.
// Optional WINGEN_POS_EN adds registered top-left coordinates (win_x, win_y).
module conv_window_gen #(
    parameter int WORDWIDTH  = 32,
    parameter int FIG_WIDTH  = 28,
    parameter int FIG_HEIGHT = 28,
    parameter int WEIGHTLEN  = 5,
    parameter int STRIDE     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_window_gen_if.slave bus
);
    localparam int K        = WEIGHTLEN;
    localparam int COL_ROWS = FIG_HEIGHT - K + 1;
    localparam int CW       = (FIG_WIDTH > 1) ? $clog2(FIG_WIDTH) : 1;
    localparam int RW       = (COL_ROWS > 1) ? $clog2(COL_ROWS) : 1;
    localparam int PW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    // col_cnt / row_cnt of the final emitted window of a frame
    localparam int LAST_X   = ((FIG_WIDTH - K) / STRIDE) * STRIDE + K - 1;
    localparam int LAST_Y   = ((COL_ROWS - 1) / STRIDE) * STRIDE;

    logic [WORDWIDTH-1:0]       win_reg    [K][K];
    logic [WORDWIDTH-1:0]       shift_next [K][K];
    logic [WORDWIDTH*K*K-1:0]   win_out_reg;
    logic [WORDWIDTH*K*K-1:0]   win_out_next;
    logic [CW-1:0]              col_cnt_reg;
    logic [RW-1:0]              row_cnt_reg;
    logic [PW-1:0]              x_phase_reg;
    logic [PW-1:0]              y_phase_reg;
    logic                       win_valid_reg;
    logic                       win_last_reg;
    logic                       frame_done_reg;
    logic                       overflow_reg;
    logic                       col_ready;
    logic                       accept;
    logic                       emit;
    logic                       col_wrap;
    logic                       row_wrap;
    logic                       is_last;

    assign col_ready = !win_valid_reg || bus.win_ready;
    assign accept    = bus.col_valid && col_ready;
    assign col_wrap  = (col_cnt_reg == CW'(FIG_WIDTH - 1));
    assign row_wrap  = (row_cnt_reg == RW'(COL_ROWS - 1));
    assign emit      = (col_cnt_reg >= CW'(K - 1)) && (x_phase_reg == '0) && (y_phase_reg == '0);
    assign is_last   = (col_cnt_reg == CW'(LAST_X)) && (row_cnt_reg == RW'(LAST_Y));

    genvar gi, gj;
    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K - 1; gj++) begin : g_shift
                assign shift_next[gi][gj] = win_reg[gi][gj+1];
            end
            assign shift_next[gi][K-1] = bus.col_in[gi*WORDWIDTH +: WORDWIDTH];
            for (gj = 0; gj < K; gj++) begin : g_pack
                assign win_out_next[(gi*K+gj)*WORDWIDTH +: WORDWIDTH] = shift_next[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_reg <= '{default: '0};
        end else if (accept) begin
            win_reg <= shift_next;
        end
    end

    // Position and stride-phase counters; phases restart at row / frame starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
            x_phase_reg <= '0;
            y_phase_reg <= '0;
        end else if (accept) begin
            if (col_wrap) begin
                col_cnt_reg <= '0;
                x_phase_reg <= '0;
                if (row_wrap) begin
                    row_cnt_reg <= '0;
                    y_phase_reg <= '0;
                end else begin
                    row_cnt_reg <= row_cnt_reg + 1'b1;
                    y_phase_reg <= (y_phase_reg == PW'(STRIDE - 1)) ? '0 : y_phase_reg + 1'b1;
                end
            end else begin
                col_cnt_reg <= col_cnt_reg + 1'b1;
                if (col_cnt_reg >= CW'(K - 1)) begin
                    x_phase_reg <= (x_phase_reg == PW'(STRIDE - 1)) ? '0 : x_phase_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_out_reg    <= '0;
            win_valid_reg  <= 1'b0;
            win_last_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (accept && emit) begin
                win_out_reg   <= win_out_next;
                win_valid_reg <= 1'b1;
                win_last_reg  <= is_last;
            end else if (bus.win_ready) begin
                win_valid_reg <= 1'b0;
            end
            frame_done_reg <= win_valid_reg && bus.win_ready && win_last_reg;
            // A new drop outranks a coincident clear
            if (bus.col_valid && !col_ready) begin
                overflow_reg <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_reg <= 1'b0;
            end
        end
    end

`ifdef WINGEN_POS_EN
    logic [CW-1:0] win_x_reg;
    logic [RW-1:0] win_y_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_x_reg <= '0;
            win_y_reg <= '0;
        end else if (accept && emit) begin
            win_x_reg <= col_cnt_reg - CW'(K - 1);
            win_y_reg <= row_cnt_reg;
        end
    end

    assign bus.win_x = win_x_reg;
    assign bus.win_y = win_y_reg;
`endif

    assign bus.col_ready  = col_ready;
    assign bus.win_out    = win_out_reg;
    assign bus.win_valid  = win_valid_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen: STRIDE=1 and STRIDE=2 instances checked every
// cycle against a position/history model; WINGEN_POS_EN also checks win_x/win_y.
module tb_conv_window_gen;
    localparam int W  = 32;
    localparam int K  = 5;
    localparam int FW = 28;
    localparam int FH = 28;
    localparam int CR = FH - K + 1;
    localparam int WB = W * K * K;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_gen_if #(.WORDWIDTH(W), .WEIGHTLEN(K), .FIG_WIDTH(FW), .FIG_HEIGHT(FH)) bus0 ();
    conv_window_gen_if #(.WORDWIDTH(W), .WEIGHTLEN(K), .FIG_WIDTH(FW), .FIG_HEIGHT(FH)) bus1 ();

    conv_window_gen #(.WORDWIDTH(W), .FIG_WIDTH(FW), .FIG_HEIGHT(FH), .WEIGHTLEN(K), .STRIDE(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    conv_window_gen #(.WORDWIDTH(W), .FIG_WIDTH(FW), .FIG_HEIGHT(FH), .WEIGHTLEN(K), .STRIDE(2))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [W*K-1:0] col_in_d    [2];
    logic           col_valid_d [2];
    logic           win_ready_d [2];
    logic           clr_d       [2];
    logic [WB-1:0]  dwin        [2];
    logic           dvalid [2], dready [2], dfd [2], dov [2];

    assign bus0.col_in = col_in_d[0];       assign bus1.col_in = col_in_d[1];
    assign bus0.col_valid = col_valid_d[0]; assign bus1.col_valid = col_valid_d[1];
    assign bus0.win_ready = win_ready_d[0]; assign bus1.win_ready = win_ready_d[1];
    assign bus0.clr_overflow = clr_d[0];    assign bus1.clr_overflow = clr_d[1];
    assign dwin[0] = bus0.win_out;          assign dwin[1] = bus1.win_out;
    assign dvalid[0] = bus0.win_valid;      assign dvalid[1] = bus1.win_valid;
    assign dready[0] = bus0.col_ready;      assign dready[1] = bus1.col_ready;
    assign dfd[0] = bus0.frame_done;        assign dfd[1] = bus1.frame_done;
    assign dov[0] = bus0.overflow;          assign dov[1] = bus1.overflow;
`ifdef WINGEN_POS_EN
    logic [4:0] dwx [2], dwy [2];
    assign dwx[0] = bus0.win_x; assign dwx[1] = bus1.win_x;
    assign dwy[0] = bus0.win_y; assign dwy[1] = bus1.win_y;
`endif

    int s_of[2]    = '{1, 2};
    int npf_lit[2] = '{576, 144};
    int nwx[2]     = '{24, 12};

    // Reference model: frame position, last K columns, expected output state
    int             mx [2], my [2], ex [2], ey [2];
    logic           ev [2], elast [2], efd [2], eov [2];
    logic [WB-1:0]  ewin [2];
    logic [W*K-1:0] hist [2][K];
    int             dcnt [2];

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int cyc = 0;
    int clean_cnt = 0;

    task automatic check(input string nm, input int i, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, i, $time, act, exp);
        end
    endtask

    function automatic logic [W*K-1:0] make_col(input int y, input int x, input logic rnd);
        logic [W*K-1:0] c;
        logic [31:0]    u;
        for (int r = 0; r < K; r++) begin
            u = $urandom();
            c[r*W +: W] = {(rnd ? u[15:0] : 16'h0), 16'((y + r) * 256 + x)};
        end
        return c;
    endfunction

    task automatic model_reset(input int i);
        mx[i] = 0; my[i] = 0; ex[i] = 0; ey[i] = 0;
        ev[i] = 1'b0; elast[i] = 1'b0; efd[i] = 1'b0; eov[i] = 1'b0;
        ewin[i] = '0;
        for (int c = 0; c < K; c++) hist[i][c] = '0;
    endtask

    task automatic model_step(input int i);
        logic rdy, acc, emit, last;
        int   xo;
        rdy  = !ev[i] || win_ready_d[i];
        acc  = col_valid_d[i] && rdy;
        emit = 1'b0;
        last = 1'b0;
        xo   = mx[i] - (K - 1);
        efd[i] = ev[i] && win_ready_d[i] && elast[i];
        if (col_valid_d[i] && !rdy) eov[i] = 1'b1;
        else if (clr_d[i]) eov[i] = 1'b0;
        if (acc) begin
            for (int c = 0; c < K - 1; c++) hist[i][c] = hist[i][c+1];
            hist[i][K-1] = col_in_d[i];
            emit = (xo >= 0) && (xo % s_of[i] == 0) && (my[i] % s_of[i] == 0);
            last = (xo == ((FW - K) / s_of[i]) * s_of[i]) && (my[i] == ((CR - 1) / s_of[i]) * s_of[i]);
        end
        if (emit) begin
            ev[i] = 1'b1; elast[i] = last; ex[i] = xo; ey[i] = my[i];
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    ewin[i][(r*K+c)*W +: W] = hist[i][c][r*W +: W];
        end else if (win_ready_d[i]) begin
            ev[i] = 1'b0;
        end
        if (acc) begin
            mx[i]++;
            if (mx[i] == FW) begin
                mx[i] = 0;
                my[i]++;
                if (my[i] == CR) my[i] = 0;
            end
        end
    endtask

    task automatic drive();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            logic wr, cv, cl, rnd;
            wr = 1'b1; cv = 1'b0; cl = 1'b0; rnd = 1'b0;
            case (mode)
                0: begin wr = 1'b1; cv = 1'b1; end
                1: begin wr = (cyc % 2 == 1); cv = !ev[i] || wr; end
                2: begin
                    wr  = ($urandom % 4) != 0;
                    cv  = (!ev[i] || wr) && ($urandom % 10 < 7);
                    if ($urandom % 32 == 0) cv = 1'b1;
                    cl  = ($urandom % 16) == 0;
                    rnd = 1'b1;
                end
                3: begin wr = 1'b0; cv = 1'b1; end
                default: begin wr = 1'b0; cl = 1'b1; end
            endcase
            if (!rst_n) cv = 1'b0;
            win_ready_d[i] = wr;
            col_valid_d[i] = cv;
            clr_d[i]       = cl;
            col_in_d[i]    = make_col(my[i], mx[i], rnd);
        end
        if (mode == 2) clean_cnt = 0;
        else clean_cnt++;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic [WB-1:0] lit;
            int idx, px;
            check("col_ready", i, WB'(dready[i]), WB'(!ev[i] || win_ready_d[i]));
            check("win_valid", i, WB'(dvalid[i]), WB'(ev[i]));
            check("win_out", i, dwin[i], ewin[i]);
            check("frame_done", i, WB'(dfd[i]), WB'(efd[i]));
            check("overflow", i, WB'(dov[i]), WB'(eov[i]));
`ifdef WINGEN_POS_EN
            check("win_x", i, WB'(dwx[i]), WB'(ex[i]));
            check("win_y", i, WB'(dwy[i]), WB'(ey[i]));
`endif
            if (dfd[i]) begin
                check("frame_len", i, WB'(dcnt[i]), WB'(npf_lit[i]));
                dcnt[i] = 0;
            end
            if (dvalid[i] && win_ready_d[i]) begin
                idx = dcnt[i];
                px  = (idx / nwx[i]) * s_of[i] * 256 + (idx % nwx[i]) * s_of[i];
                check("raster_word0", i, WB'(dwin[i][15:0]), WB'(px));
                if (i == 1 && idx == 1) check("s2_win1", i, WB'(dwin[i][15:0]), WB'(2));
                if (i == 1 && idx == 12) check("s2_row2", i, WB'(dwin[i][15:0]), WB'(512));
                if (i == 0 && idx == 0 && clean_cnt > 40) begin
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            lit[(r*K+c)*W +: W] = W'(r * 256 + c);
                    check("first_win", i, dwin[i], lit);
                end
`ifdef WINGEN_POS_EN
                check("pos_decode_x", i, WB'(dwx[i]), WB'(dwin[i][7:0]));
                check("pos_decode_y", i, WB'(dwy[i]), WB'(dwin[i][15:8]));
`endif
                dcnt[i]++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive();
            #1;
            compare_all();
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) model_reset(i);
                else model_step(i);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            col_in_d[i] = '0; col_valid_d[i] = 1'b0; win_ready_d[i] = 1'b0; clr_d[i] = 1'b0;
            model_reset(i);
            dcnt[i] = 0;
        end
        @(negedge clk);
        run(3);
        rst_n = 1'b1;
        mode = 0; run(700);
        mode = 1; run(1500);
        mode = 2; run(2000);
        mode = 3; run(60);
        for (int i = 0; i < 2; i++) check("ovf_set", i, WB'(dov[i]), WB'(1));
        mode = 4; run(2);
        for (int i = 0; i < 2; i++) check("ovf_clr", i, WB'(dov[i]), WB'(0));
        mode = 0;
        n = 0;
        while (dcnt[0] != 100 && n < 2000) begin
            run(1);
            n++;
        end
        check("win100_reached", 0, WB'(dcnt[0]), WB'(100));
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", i, WB'(dvalid[i]), WB'(0));
            check("rst_win", i, dwin[i], '0);
            check("rst_ovf", i, WB'(dov[i]), WB'(0));
            check("rst_fd", i, WB'(dfd[i]), WB'(0));
            model_reset(i);
            dcnt[i] = 0;
        end
        run(3);
        rst_n = 1'b1;
        run(720);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
